regbus_arb: RTL
===============

# regbus_arb

Two-master round-robin arbiter sharing the Avalon-MM style register bus of the Ethernet MAC between `execcmd` (master 0) and a second command source (master 1, e.g. host/debug path). It sits in the `clk_2` register domain, between the masters' `reg_*_c2` ports and the MAC's `address/read/write/waitrequest` ports. It serialises accesses, and it bounds every access with a waitrequest timeout so a hung slave cannot stall `execcmd`.

## Interface
Parameters:
- `AW`, 14, register address width
- `DW`, 32, data width
- `TIMEOUT`, 255, maximum cycles `s_waitrequest` may stay high in one access (1..255)

Ports:
- `clk` in 1: register-bus clock, single clock domain
- `rst` in 1: asynchronous, active-low reset
- `m0_addr`/`m1_addr` in AW: requester address
- `m0_rd`/`m1_rd` in 1: read request, held until `mN_ready`
- `m0_wr`/`m1_wr` in 1: write request, held until `mN_ready`
- `m0_writedata`/`m1_writedata` in DW: write data
- `m0_ready`/`m1_ready` out 1: one-cycle completion pulse
- `m0_readdata`/`m1_readdata` out DW: read data, valid with `mN_ready`, held until the next read completion for that master
- `m0_err`/`m1_err` out 1: pulses with `mN_ready` on a timeout or an illegal request
- `s_addr` out AW: slave address
- `s_rd`, `s_wr` out 1: slave read and write strobes
- `s_writedata` out DW: slave write data
- `s_waitrequest` in 1: slave stall
- `s_readdata` in DW: slave read data, valid when `s_waitrequest` is low during a read
- `grant` out 2: one-hot current owner, 00 when idle
- `err_cnt` out 8: saturating count of timeouts

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - A master is requesting when `rd|wr` is high.
  - If both masters request, grant goes to the master not served last. The `last` pointer resets to 1, so m0 wins the first tie.
  - On grant, latch addr, writedata and command into the `s_*` registers, set `grant`, and go to ACCESS.
- Illegal request (`rd` and `wr` both high):
  - No slave access is made.
  - Go directly to RESP with `err` set.
  - `readdata` is unchanged.
- ACCESS:
  - `s_rd` or `s_wr` is high.
  - When `s_waitrequest` is low: capture `s_readdata` (reads only), deassert the strobe, go to RESP.
  - Timeout counter increments each cycle `s_waitrequest` is high. On reaching `TIMEOUT`: deassert the strobe, load `32'hDEAD_BEEF` as readdata for reads, set `err`, increment `err_cnt` (saturates at 255), go to RESP.
- RESP:
  - Pulse `mN_ready` (and `mN_err` if set) for one cycle.
  - Update `last`, clear `grant`, return to IDLE.
- Masters must drop `rd`/`wr` on the cycle after `ready`. A request withdrawn early is ignored; the transaction still completes and `ready` still pulses.
- Writes never modify `mN_readdata`.

## Timing
- Reset values: all outputs 0, `readdata` 0, `err_cnt` 0, state IDLE, `last`=1.
- Reset mid-access immediately drops `s_rd`/`s_wr`. No completion is issued.
- Latency with a zero-wait slave:
  - Request seen in IDLE at cycle 0.
  - `s_rd`/`s_wr` high at cycle 1.
  - `ready` at cycle 2.
  - Minimum 3 cycles per transaction. The other master's access can start on the cycle after RESP (IDLE grant).
- Each waitrequest cycle adds one cycle of latency. Timeout `ready` arrives at cycle `TIMEOUT+2`.
- Illegal request: `ready`+`err` at cycle 1.
- `s_*` outputs are registered; there is no combinational path from master inputs to the slave.

## Structure
- `regbus_pkg`:
  - `AW`/`DW` defaults
  - state enum `{IDLE, ACCESS, RESP}`
  - `TIMEOUT_DATA = 32'hDEAD_BEEF`
- Sub-module `rr_arb2`: two-way round-robin grant with `last` pointer update; combinational grant, registered pointer.
- Timeout counter and `err_cnt` stay in the top level.

## Test plan
- m0 read of addr 0x002 (MAC command_config), zero-wait slave returning 0x00000803 -> `s_rd` high 1 cycle, `m0_ready` at cycle 2, `m0_readdata`=0x00000803, `m0_err`=0.
- m0 and m1 both request writes in the same cycle after reset -> m0 served first, then m1. `s_addr`/`s_writedata` match each master in turn; two `ready` pulses 3 cycles apart.
- m1 read with slave holding `s_waitrequest` high for 300 cycles, `TIMEOUT`=255 -> `m1_ready`+`m1_err` at cycle 257, `m1_readdata`=0xDEADBEEF, `err_cnt`=1. A further 300 timeouts -> `err_cnt`=255.
- m0 asserts `rd` and `wr` together -> no `s_rd`/`s_wr` activity, `m0_ready`+`m0_err` at cycle 1, `m0_readdata` unchanged.
- `rst` driven low while in ACCESS with waitrequest high -> `s_rd`, `grant`, `ready` all 0 asynchronously. After release, a new m1 request completes normally.
- m0 streams 3 back-to-back reads while m1 requests continuously -> grants alternate m0, m1, m0, m1, …, with no starvation.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and constants for the two-master register-bus arbiter.
package regbus_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 32;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers which master was served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = served;
        end
    end

    // Pointer starts at m1 so m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regbus_arb.sv
// Round-robin arbiter sharing one Avalon-MM style register bus between two masters,
// with a waitrequest timeout so a hung slave cannot stall either master.
module regbus_arb
    import regbus_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic [DW-1:0] m0_writedata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_err,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [DW-1:0] m1_writedata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_err,
    output logic [AW-1:0] s_addr,
    output logic          s_rd,
    output logic          s_wr,
    output logic [DW-1:0] s_writedata,
    input  logic          s_waitrequest,
    input  logic [DW-1:0] s_readdata,
    output logic [1:0]    grant,
    output logic [7:0]    err_cnt
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic          s_rd_q, s_rd_d;
    logic          s_wr_q, s_wr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic [1:0]    req, arb_gnt;
    logic          arb_update;
    logic          sel_rd, sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          rd_done;
    logic [DW-1:0] rd_value;

    assign req       = {m1_rd | m1_wr, m0_rd | m0_wr};
    assign sel_rd    = arb_gnt[1] ? m1_rd        : m0_rd;
    assign sel_wr    = arb_gnt[1] ? m1_wr        : m0_wr;
    assign sel_addr  = arb_gnt[1] ? m1_addr      : m0_addr;
    assign sel_wdata = arb_gnt[1] ? m1_writedata : m0_writedata;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (arb_update),
        .served (owner_q),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
            err_cnt_q <= '0;
            s_addr_q  <= '0;
            s_rd_q    <= 1'b0;
            s_wr_q    <= 1'b0;
            s_wdata_q <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            err_cnt_q <= err_cnt_d;
            s_addr_q  <= s_addr_d;
            s_rd_q    <= s_rd_d;
            s_wr_q    <= s_wr_d;
            s_wdata_q <= s_wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        err_d     = err_q;
        to_cnt_d  = to_cnt_q;
        err_cnt_d = err_cnt_q;
        s_addr_d  = s_addr_q;
        s_rd_d    = s_rd_q;
        s_wr_d    = s_wr_q;
        s_wdata_d = s_wdata_q;
        rd_done   = 1'b0;
        rd_value  = s_readdata;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    owner_d  = arb_gnt[1];
                    to_cnt_d = '0;
                    err_d    = 1'b0;
                    // Simultaneous rd and wr is rejected without touching the slave.
                    if (sel_rd && sel_wr) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        s_addr_d  = sel_addr;
                        s_wdata_d = sel_wdata;
                        s_rd_d    = sel_rd;
                        s_wr_d    = sel_wr;
                        state_d   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!s_waitrequest) begin
                    s_rd_d  = 1'b0;
                    s_wr_d  = 1'b0;
                    rd_done = s_rd_q;
                    state_d = RESP;
                end else if (to_cnt_q == TO_LIMIT) begin
                    s_rd_d   = 1'b0;
                    s_wr_d   = 1'b0;
                    err_d    = 1'b1;
                    rd_done  = s_rd_q;
                    rd_value = DW'(TIMEOUT_DATA);
                    state_d  = RESP;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (rd_done) begin
            if (owner_q) begin
                rdata1_d = rd_value;
            end else begin
                rdata0_d = rd_value;
            end
        end
    end

    always_comb begin
        m0_ready   = (state_q == RESP) && !owner_q;
        m1_ready   = (state_q == RESP) && owner_q;
        m0_err     = m0_ready && err_q;
        m1_err     = m1_ready && err_q;
        arb_update = (state_q == RESP);
        grant      = 2'b00;
        if (state_q != IDLE) begin
            grant = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign s_addr      = s_addr_q;
    assign s_rd        = s_rd_q;
    assign s_wr        = s_wr_q;
    assign s_writedata = s_wdata_q;
    assign m0_readdata = rdata0_q;
    assign m1_readdata = rdata1_q;
    assign err_cnt     = err_cnt_q;

endmodule
